// File: rtl/rf_wb_scheduler_if.sv
// Writeback, issue, hazard-query and register-file write-port signals of rf_wb_scheduler.
// The master modport is the surrounding pipeline; the slave modport is the scheduler.
interface rf_wb_scheduler_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned XLEN    = 32
);
  logic [NUM_SRC-1:0]      src_valid;
  logic [5*NUM_SRC-1:0]    src_rd;
  logic [XLEN*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]      src_ready;

  logic                    iss_valid;
  logic [4:0]              iss_rd;
  logic                    iss_ready;

  logic [4:0]              q_rs1;
  logic [4:0]              q_rs2;
  logic                    q_rs1_busy;
  logic                    q_rs2_busy;

  logic                    rf_we;
  logic [4:0]              rf_rd;
  logic [XLEN-1:0]         rf_wdata;
  logic                    err_unexp;

  modport master (
    output src_valid, src_rd, src_data, iss_valid, iss_rd, q_rs1, q_rs2,
    input  src_ready, iss_ready, q_rs1_busy, q_rs2_busy, rf_we, rf_rd, rf_wdata, err_unexp
  );

  modport slave (
    input  src_valid, src_rd, src_data, iss_valid, iss_rd, q_rs1, q_rs2,
    output src_ready, iss_ready, q_rs1_busy, q_rs2_busy, rf_we, rf_rd, rf_wdata, err_unexp
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Round-robin arbiter sharing the register-file write port among writeback sources,
// with a registered write stage and a per-register busy scoreboard for decode hazards.
module rf_wb_scheduler #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned XLEN    = 32
) (
  input logic                 clk,
  input logic                 reset,
  rf_wb_scheduler_if.slave    bus_io
);

  localparam int unsigned GntW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [GntW-1:0] LastInit = GntW'(NUM_SRC - 1);

  logic [31:0]      busy_q, busy_d;
  logic [GntW-1:0]  last_grant_q, last_grant_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             err_q, err_d;

  logic [NUM_SRC-1:0] grant;
  logic [GntW-1:0]    grant_idx;
  logic               xfer;
  logic [4:0]         sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic               iss_ready;
  int unsigned        cand;

  // Search starts one past the last winner so every source gets a turn.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant_q;
    xfer      = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_SRC;
      if (!xfer && bus_io.src_valid[cand]) begin
        xfer        = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = GntW'(cand);
      end
    end
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd | bus_io.src_rd[5*i +: 5];
        sel_data = sel_data | bus_io.src_data[XLEN*i +: XLEN];
      end
    end
  end

  assign iss_ready = (bus_io.iss_rd == 5'd0) | ~busy_q[bus_io.iss_rd];

  // Clear is applied before set; the two can only target the same register if the
  // scoreboard was already inconsistent, since issue is blocked while busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (bus_io.iss_valid && iss_ready && (bus_io.iss_rd != 5'd0)) begin
      busy_d[bus_io.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    err_d        = err_q;
    if (xfer) begin
      last_grant_d = grant_idx;
      rf_we_d      = (sel_rd != 5'd0);
      rf_rd_d      = sel_rd;
      rf_wdata_d   = sel_data;
      // A write still sitting in the output stage for the same rd is not unexpected.
      if ((sel_rd != 5'd0) && !busy_q[sel_rd] && !(rf_we_q && (rf_rd_q == sel_rd))) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      last_grant_q <= LastInit;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
      err_q        <= err_d;
    end
  end

  assign bus_io.src_ready  = grant;
  assign bus_io.iss_ready  = iss_ready;
  assign bus_io.q_rs1_busy = busy_q[bus_io.q_rs1];
  assign bus_io.q_rs2_busy = busy_q[bus_io.q_rs2];
  assign bus_io.rf_we      = rf_we_q;
  assign bus_io.rf_rd      = rf_rd_q;
  assign bus_io.rf_wdata   = rf_wdata_q;
  assign bus_io.err_unexp  = err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: a behavioural scoreboard model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_rf_wb_scheduler;
  localparam int NS = 3;
  localparam int XL = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  rf_wb_scheduler_if #(.NUM_SRC(NS), .XLEN(XL)) bus ();

  rf_wb_scheduler #(.NUM_SRC(NS), .XLEN(XL)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // Model state: which registers await a write, who won last, what sits in the write stage.
  bit [31:0] m_busy  = '0;
  int        m_last  = NS - 1;
  bit        m_we    = 1'b0;
  bit [4:0]  m_rd    = '0;
  bit [31:0] m_wdata = '0;
  bit        m_err   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    for (int k = 1; k <= NS; k++) begin
      if (bus.src_valid[(m_last + k) % NS]) return (m_last + k) % NS;
    end
    return -1;
  endfunction

  function automatic bit [4:0] m_grd();
    int g = m_grant();
    return bus.src_rd[5*g +: 5];
  endfunction

  function automatic bit [31:0] m_gdata();
    int g = m_grant();
    return bus.src_data[XL*g +: XL];
  endfunction

  function automatic bit [31:0] m_next_busy();
    bit [31:0] b = m_busy;
    if (m_we) b[m_rd] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != 0 && !m_busy[bus.iss_rd]) b[bus.iss_rd] = 1'b1;
    return b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= '0; m_last <= NS - 1; m_we <= 1'b0; m_rd <= '0; m_wdata <= '0; m_err <= 1'b0;
    end else begin
      m_busy <= m_next_busy();
      if (m_grant() >= 0) begin
        m_last  <= m_grant();
        m_we    <= (m_grd() != 0);
        m_rd    <= m_grd();
        m_wdata <= m_gdata();
        if (m_grd() != 0 && !m_busy[m_grd()] && !(m_we && m_rd == m_grd())) m_err <= 1'b1;
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [NS-1:0] exp_ready;
    g = m_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("m_src_ready", bus.src_ready, exp_ready);
    chk("m_iss_ready", bus.iss_ready, (bus.iss_rd == 0) || !m_busy[bus.iss_rd]);
    chk("m_q_rs1_busy", bus.q_rs1_busy, m_busy[bus.q_rs1]);
    chk("m_q_rs2_busy", bus.q_rs2_busy, m_busy[bus.q_rs2]);
    chk("m_rf_we", bus.rf_we, m_we);
    chk("m_rf_rd", bus.rf_rd, m_rd);
    chk("m_rf_wdata", bus.rf_wdata, m_wdata);
    chk("m_err_unexp", bus.err_unexp, m_err);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] d);
    bus.src_rd[5*i +: 5]     = rd;
    bus.src_data[XL*i +: XL] = d;
  endtask

  initial begin
    logic [NS-1:0] gseq [3];
    logic [NS-1:0] acc;
    int n;
    reset = 1'b1;
    bus.src_valid = '0; bus.src_rd = '0; bus.src_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.q_rs1 = '0; bus.q_rs2 = '0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_err", bus.err_unexp, 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    cyc();
    reset = 1'b0;

    // Three sources valid together after reset: grants rotate 0,1,2.
    for (int r = 1; r <= 3; r++) begin
      bus.iss_valid = 1'b1; bus.iss_rd = 5'(r);
      @(negedge clk);
      chk("iss_ready_free", bus.iss_ready, 1);
      cyc();
    end
    bus.iss_valid = 1'b0;
    set_src(0, 5'd1, 32'h1111_1111);
    set_src(1, 5'd2, 32'h2222_2222);
    set_src(2, 5'd3, 32'h3333_3333);
    bus.src_valid = 3'b111;
    n = 0;
    for (int t = 0; t < 8 && bus.src_valid != 0; t++) begin
      @(negedge clk);
      acc = bus.src_ready;
      if (n < 3) gseq[n] = acc;
      n++;
      cyc();
      bus.src_valid = bus.src_valid & ~acc;
    end
    chk("rr_cycles", n, 3);
    chk("rr_grant0", gseq[0], 3'b001);
    chk("rr_grant1", gseq[1], 3'b010);
    chk("rr_grant2", gseq[2], 3'b100);
    cyc(); cyc();
    bus.q_rs1 = 5'd1; bus.q_rs2 = 5'd3;
    @(negedge clk);
    chk("rr_x1_clear", bus.q_rs1_busy, 0);
    chk("rr_x3_clear", bus.q_rs2_busy, 0);
    cyc();

    // Issue x5, then src1 writes it back.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    cyc();
    bus.iss_valid = 1'b0; bus.q_rs1 = 5'd5;
    @(negedge clk);
    chk("x5_busy", bus.q_rs1_busy, 1);
    chk("x5_waw_stall", bus.iss_ready, 0);
    set_src(1, 5'd5, 32'hDEAD_BEEF);
    bus.src_valid = 3'b010;
    #1;
    chk("x5_ready", bus.src_ready, 3'b010);
    cyc();
    bus.src_valid = '0;
    @(negedge clk);
    chk("x5_we", bus.rf_we, 1);
    chk("x5_rd", bus.rf_rd, 5);
    chk("x5_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    chk("x5_busy_in_stage", bus.q_rs1_busy, 1);
    cyc();
    @(negedge clk);
    chk("x5_cleared", bus.q_rs1_busy, 0);
    cyc();

    // Issue x7 while the x4 write is in the output stage.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    cyc();
    bus.iss_valid = 1'b0;
    set_src(0, 5'd4, 32'h0000_0444);
    bus.src_valid = 3'b001;
    cyc();
    bus.src_valid = '0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    @(negedge clk);
    chk("x4_stage_rd", bus.rf_rd, 4);
    cyc();
    bus.iss_valid = 1'b0; bus.q_rs1 = 5'd7; bus.q_rs2 = 5'd4;
    @(negedge clk);
    chk("x7_set", bus.q_rs1_busy, 1);
    chk("x4_clr", bus.q_rs2_busy, 0);
    cyc();

    // rd=0 writeback is accepted but never written.
    set_src(0, 5'd0, 32'h0000_1234);
    bus.src_valid = 3'b001;
    @(negedge clk);
    chk("x0_ready", bus.src_ready, 3'b001);
    cyc();
    set_src(1, 5'd0, 32'h0000_5678);
    bus.src_valid = 3'b011;
    @(negedge clk);
    chk("x0_next_src1", bus.src_ready, 3'b010);
    chk("x0_no_we", bus.rf_we, 0);
    cyc();
    bus.src_valid = '0;
    @(negedge clk);
    chk("x0_no_err", bus.err_unexp, 0);
    cyc();

    // Unexpected writeback to non-busy x9.
    set_src(2, 5'd9, 32'h0000_0099);
    bus.src_valid = 3'b100;
    cyc();
    bus.src_valid = '0;
    @(negedge clk);
    chk("x9_we", bus.rf_we, 1);
    chk("x9_rd", bus.rf_rd, 9);
    chk("x9_err", bus.err_unexp, 1);
    cyc(); cyc();
    @(negedge clk);
    chk("x9_err_sticky", bus.err_unexp, 1);
    cyc();

    // Reset while x3's write is in the output stage.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    cyc();
    bus.iss_valid = 1'b0; bus.q_rs1 = 5'd3;
    set_src(1, 5'd3, 32'h0000_0033);
    bus.src_valid = 3'b010;
    cyc();
    bus.src_valid = '0;
    @(negedge clk);
    chk("pre_rst_we", bus.rf_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", bus.rf_we, 0);
    chk("mid_rst_err", bus.err_unexp, 0);
    chk("mid_rst_busy", bus.q_rs1_busy, 0);
    cyc();
    reset = 1'b0;
    set_src(0, 5'd0, 32'h0); set_src(1, 5'd0, 32'h0); set_src(2, 5'd0, 32'h0);
    bus.src_valid = 3'b111;
    @(negedge clk);
    chk("post_rst_grant", bus.src_ready, 3'b001);
    cyc();
    bus.src_valid = '0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Shares the register file's single write port among NUM_SRC writeback sources: ALU (src0), LSU (src1) and MDU (src2).
- Uses round-robin arbitration with a registered write stage.
- Keeps a per-register busy scoreboard. Decode uses it to stall on RAW/WAW hazards.
- Sits between the execution units and the register file. Drives the file's rd_address, write_data and write_enable.

Parameters:
NUM_SRC, 3, number of writeback requesters (2..4)
XLEN, 32, data width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
src_valid  input  NUM_SRC  per-source writeback request
src_rd  input  5*NUM_SRC  destination register, source i at bits [5i+4:5i]
src_data  input  XLEN*NUM_SRC  writeback data, source i at [XLEN*i+XLEN-1:XLEN*i]
src_ready  output  NUM_SRC  one-hot grant; transfer when valid&ready at posedge
iss_valid  input  1  decode issues an instruction that will write iss_rd
iss_rd  input  5  destination of the issuing instruction
iss_ready  output  1  issue may proceed (no WAW)
q_rs1  input  5  hazard query address 1
q_rs2  input  5  hazard query address 2
q_rs1_busy  output  1  q_rs1 has a pending write
q_rs2_busy  output  1  q_rs2 has a pending write
rf_we  output  1  register-file write_enable
rf_rd  output  5  register-file rd_address
rf_wdata  output  XLEN  register-file write_data
err_unexp  output  1  sticky: writeback to a non-busy register

Behaviour:
- State:
  - busy[31:1] scoreboard; busy[0] is constant 0.
  - last_grant pointer, log2(NUM_SRC) bits.
  - Output register {rf_we, rf_rd, rf_wdata}.
  - err_unexp flag.
- Reset (async) values:
  - busy = 0; last_grant = NUM_SRC-1, so src0 has first priority.
  - rf_we = 0, rf_rd = 0, rf_wdata = 0, err_unexp = 0.
  - All in-flight requests are dropped. Sources must re-present after reset.
- Arbitration is combinational, round-robin:
  - Search src_valid starting at last_grant+1, mod NUM_SRC. The first valid source gets src_ready.
  - At most one src_ready is high per cycle. src_ready = 0 when no source is valid.
  - Sources must not make src_valid depend on src_ready.
  - A valid source must hold rd/data stable until accepted.
- Fairness: on a transfer, last_grant <= granted index. With all sources continuously valid, grants rotate 0,1,2,0,...
- Throughput: one writeback accepted per cycle. The write port never back-pressures.
- Write stage latency = 1:
  - A transfer at edge N loads rf_we = (rd != 0), rf_rd = rd, rf_wdata = data.
  - These are visible in cycle N+1. The register file commits at edge N+1.
  - With no transfer, rf_we <= 0; rf_rd and rf_wdata hold their values.
- Scoreboard set:
  - iss_ready = (iss_rd == 0) | ~busy[iss_rd].
  - On iss_valid & iss_ready with iss_rd != 0: busy[iss_rd] <= 1.
- Scoreboard clear: when rf_we = 1 in a cycle, busy[rf_rd] <= 0 at the end of that cycle.
  - The register stays busy while its write sits in the output stage.
  - A read issued after the clear therefore sees the committed value.
- Simultaneous set and clear of the same rd cannot occur, because iss_ready = 0 while the register is busy.
- Set and clear of different registers in the same cycle both take effect.
- Queries: q_rsX_busy = busy[q_rsX], combinational; address 0 always returns 0.
- rd = 0 writeback:
  - Accepted (src_ready as normal) and rotates the pointer.
  - No rf_we, no scoreboard change, no error.
- Writeback to rd != 0 with busy[rd] = 0 and no identical pending rf_rd:
  - The write is still performed.
  - err_unexp <= 1, cleared only by reset.

Test Plan:
- Reset, then issue x5 -> q_rs1=5 gives busy=1; iss_ready=0 for x5. src1 writes x5=0xDEADBEEF -> src_ready=3'b010 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; busy clears the cycle after.
- Issue x1,x2,x3; all three sources valid continuously with rd 1,2,3 -> grants 0,1,2 in consecutive cycles; rf_rd sequence 1,2,3 at latency 1; all busy clear.
- Issue x7 while the x4 writeback is in the output stage -> both take effect: busy[7]=1, busy[4]=0.
- src0 writeback rd=0, data=0x1234 -> src_ready[0]=1; rf_we stays 0; err_unexp stays 0; next grant goes to src1 if valid.
- src2 writes x9 with x9 not busy -> rf_we=1, rf_rd=9; err_unexp=1 and sticky until reset.
- Assert reset mid-stream with x3 busy and rf_we=1 -> immediately rf_we=0, busy all 0, err_unexp=0; the first grant after release goes to src0.
